// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter slice.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } uart_state_e;

    localparam int NUM_REQ_DEF      = 4;
    localparam int BUSY_TIMEOUT_DEF = 15;

    // Round-robin successor of a granted index.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared tx engine.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = 8
) ();

    localparam int ID_W = $clog2(NUM_REQ);

    // Handshake: a requester raises req[i] with its byte on req_data and holds
    // both until ack[i] pulses for one cycle; that cycle is also the single
    // tx_start pulse, and tx_data stays stable until the arbiter is idle again.
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy;
    logic [ID_W-1:0]           grant_id;
    logic                      active;
    logic                      err_timeout;
    uart_state_e               dbg_state;

    modport master (
        output req, req_data, tx_busy,
        input  ack, tx_start, tx_data, grant_id, active, err_timeout, dbg_state
    );

    modport slave (
        input  req, req_data, tx_busy,
        output ack, tx_start, tx_data, grant_id, active, err_timeout, dbg_state
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: lowest set request at or above the pointer, wrapping.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    winner_o,
    output logic               valid_o
);

    logic [2*NUM_REQ-1:0] dbl_req;
    logic [2*NUM_REQ-1:0] above_ptr;
    logic [2*NUM_REQ-1:0] masked;
    int                   first;

    // The upper copy of req supplies the wrapped-around candidates.
    always_comb begin
        dbl_req   = {req_i, req_i};
        above_ptr = {(2*NUM_REQ){1'b1}} << ptr_i;
        masked    = dbl_req & above_ptr;
        first     = 0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (masked[i]) first = i;
        end
        winner_o  = ID_W'(first % NUM_REQ);
        valid_o   = |req_i;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx engine, with busy tracking and a start-ack timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = 8;
    // The error becomes visible BUSY_TIMEOUT cycles after the tx_start cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((BUSY_TIMEOUT >= 2) ? BUSY_TIMEOUT - 2 : 0);

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ID_W-1:0]   gid_q, gid_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [ID_W-1:0]    pick_idx;
    logic               pick_vld;
    logic               decide;
    logic [NUM_REQ-1:0] ack_vec;

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .winner_o (pick_idx),
        .valid_o  (pick_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        decide  = 1'b0;

        case (state_q)
            IDLE: begin
                decide = !bus.tx_busy;
            end
            ISSUE: begin
                ptr_d   = ID_W'(rr_next(int'(gid_q), NUM_REQ));
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                // The cycle busy drops already counts as an idle decision cycle.
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                    decide  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (decide && pick_vld) begin
            data_d  = bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
            gid_d   = pick_idx;
            state_d = ISSUE;
        end
    end

    always_comb begin
        ack_vec = '0;
        if (state_q == ISSUE) ack_vec[gid_q] = 1'b1;
    end

    assign bus.ack         = ack_vec;
    assign bus.tx_start    = (state_q == ISSUE);
    assign bus.tx_data     = data_q;
    assign bus.grant_id    = gid_q;
    assign bus.active      = (state_q != IDLE);
    assign bus.err_timeout = err_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural round-robin model and a fixed-length tx engine model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int TO    = 15;
    localparam int FRAME = 10;
    localparam int IDW   = $clog2(N);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .BUSY_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: busy rises the cycle after tx_start and stays high FRAME cycles.
    int busy_left;
    bit model_on   = 1'b1;
    bit force_busy = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          busy_left <= 0;
        else if (model_on && bus.tx_start)   busy_left <= FRAME;
        else if (busy_left != 0)             busy_left <= busy_left - 1;
    end
    assign bus.tx_busy = (busy_left != 0) || force_busy;

    logic [N-1:0] req_v;
    logic [W-1:0] data_v [N];
    int           m_ptr;

    task automatic drive();
        logic [N*W-1:0] packed_data;
        for (int i = 0; i < N; i++) packed_data[i*W +: W] = data_v[i];
        bus.req      = req_v;
        bus.req_data = packed_data;
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic wait_start(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.active === 1'b0) seen = 1'b1;
        end
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        force_busy = 1'b0;
        req_v      = '0;
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_v = '0;
        drive();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.ack, bus.tx_start} !== '0) begin
            n_fail++; $display("FAIL reset_ack_start: got ack=%b start=%b, want 0", bus.ack, bus.tx_start);
        end
        n_checks++;
        if (bus.tx_data !== '0 || bus.grant_id !== '0) begin
            n_fail++; $display("FAIL reset_data_gid: got data=%h gid=%0d, want 0", bus.tx_data, bus.grant_id);
        end
        n_checks++;
        if ({bus.active, bus.err_timeout} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: got active=%b err=%b, want 0", bus.active, bus.err_timeout);
        end
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_single();
        int  exp;
        bit  ok;
        @(negedge clk);
        for (int i = 0; i < N; i++) data_v[i] = W'($urandom);
        data_v[2] = 8'hA5;
        req_v     = 4'b0100;
        drive();
        exp = model_pick(req_v, m_ptr);
        @(negedge clk);
        n_checks++;
        if (bus.tx_start !== 1'b1 || bus.ack !== 4'b0100) begin
            n_fail++; $display("FAIL single_start_ack: got start=%b ack=%b, want 1/0100", bus.tx_start, bus.ack);
        end
        n_checks++;
        if (bus.tx_data !== 8'hA5 || bus.grant_id !== IDW'(exp)) begin
            n_fail++; $display("FAIL single_data_gid: got %h/%0d, want a5/%0d", bus.tx_data, bus.grant_id, exp);
        end
        m_ptr     = (exp + 1) % N;
        req_v     = '0;
        data_v[2] = 8'h3C;
        drive();
        @(negedge clk);
        n_checks++;
        if (bus.tx_start !== 1'b0 || bus.ack !== '0) begin
            n_fail++; $display("FAIL single_pulse_len: got start=%b ack=%b, want 0", bus.tx_start, bus.ack);
        end
        for (int i = 0; i < 30 && bus.tx_busy; i++) @(negedge clk);
        n_checks++;
        if (bus.tx_busy !== 1'b0 || bus.active !== 1'b1 || bus.tx_data !== 8'hA5) begin
            n_fail++; $display("FAIL single_busy_fall: got busy=%b active=%b data=%h, want 0/1/a5", bus.tx_busy, bus.active, bus.tx_data);
        end
        @(negedge clk);
        n_checks++;
        if (bus.active !== 1'b0) begin
            n_fail++; $display("FAIL single_active_fall: got %b, want 0", bus.active);
        end
    endtask

    task automatic test_contention();
        int exp;
        int last;
        bit ok;
        apply_reset();
        for (int i = 0; i < N; i++) data_v[i] = W'($urandom);
        req_v = 4'b1111;
        drive();
        last = 0;
        for (int g = 0; g < N; g++) begin
            exp = model_pick(req_v, m_ptr);
            wait_start(40, ok);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL cont_start_%0d: got no tx_start, want one", g);
            end
            n_checks++;
            if (bus.grant_id !== IDW'(exp) || bus.ack !== N'(1) << exp || bus.tx_data !== data_v[exp]) begin
                n_fail++; $display("FAIL cont_grant_%0d: got gid=%0d ack=%b data=%h, want %0d/%b/%h",
                                   g, bus.grant_id, bus.ack, bus.tx_data, exp, N'(1) << exp, data_v[exp]);
            end
            if (g > 0) begin
                n_checks++;
                if (cyc - last !== FRAME + 2) begin
                    n_fail++; $display("FAIL cont_gap_%0d: got %0d cycles, want %0d", g, cyc - last, FRAME + 2);
                end
            end
            last       = cyc;
            m_ptr      = (exp + 1) % N;
            req_v[exp] = 1'b0;
            drive();
        end
        wait_idle(40, ok);
    endtask

    task automatic test_rotation();
        int exp;
        bit ok;
        req_v = 4'b0010;
        drive();
        exp = model_pick(req_v, m_ptr);
        wait_start(20, ok);
        n_checks++;
        if (!ok || bus.grant_id !== IDW'(exp)) begin
            n_fail++; $display("FAIL rot_first: got seen=%b gid=%0d, want 1/%0d", ok, bus.grant_id, exp);
        end
        m_ptr = (exp + 1) % N;
        req_v = '0;
        drive();
        wait_idle(40, ok);
        for (int i = 0; i < N; i++) data_v[i] = W'($urandom);
        req_v = 4'b0011;
        drive();
        for (int g = 0; g < 2; g++) begin
            exp = model_pick(req_v, m_ptr);
            wait_start(40, ok);
            n_checks++;
            if (!ok || bus.grant_id !== IDW'(exp) || bus.tx_data !== data_v[exp]) begin
                n_fail++; $display("FAIL rot_grant_%0d: got seen=%b gid=%0d data=%h, want %0d/%h",
                                   g, ok, bus.grant_id, bus.tx_data, exp, data_v[exp]);
            end
            m_ptr      = (exp + 1) % N;
            req_v[exp] = 1'b0;
            drive();
        end
        wait_idle(40, ok);
    endtask

    task automatic test_timeout();
        bit ok;
        model_on = 1'b0;
        req_v    = 4'b0001;
        drive();
        wait_start(5, ok);
        n_checks++;
        if (!ok || bus.ack !== 4'b0001) begin
            n_fail++; $display("FAIL to_ack: got seen=%b ack=%b, want 1/0001", ok, bus.ack);
        end
        m_ptr = 1;
        req_v = '0;
        drive();
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.err_timeout, bus.active} !== 2'b01) begin
                n_fail++; $display("FAIL to_early_%0d: got err=%b active=%b, want 0/1", i, bus.err_timeout, bus.active);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({bus.err_timeout, bus.active} !== 2'b10) begin
            n_fail++; $display("FAIL to_fire: got err=%b active=%b, want 1/0", bus.err_timeout, bus.active);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.err_timeout !== 1'b1) begin
            n_fail++; $display("FAIL to_sticky: got %b, want 1", bus.err_timeout);
        end
        model_on = 1'b1;
    endtask

    task automatic test_busy_engine();
        int exp;
        bit ok;
        force_busy = 1'b1;
        req_v      = 4'b0010;
        drive();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.tx_start, bus.ack} !== '0) begin
                n_fail++; $display("FAIL busy_hold_%0d: got start=%b ack=%b, want 0", i, bus.tx_start, bus.ack);
            end
        end
        force_busy = 1'b0;
        exp = model_pick(req_v, m_ptr);
        @(negedge clk);
        n_checks++;
        if (bus.tx_start !== 1'b1 || bus.ack !== 4'b0010 || bus.grant_id !== IDW'(exp)) begin
            n_fail++; $display("FAIL busy_release: got start=%b ack=%b gid=%0d, want 1/0010/%0d",
                               bus.tx_start, bus.ack, bus.grant_id, exp);
        end
        n_checks++;
        if (bus.err_timeout !== 1'b1) begin
            n_fail++; $display("FAIL busy_err_sticky: got %b, want 1", bus.err_timeout);
        end
        m_ptr = (exp + 1) % N;
        req_v = '0;
        drive();
        wait_idle(40, ok);
    endtask

    task automatic test_withdraw();
        force_busy = 1'b1;
        req_v      = 4'b0100;
        drive();
        repeat (3) @(negedge clk);
        req_v = '0;
        drive();
        @(negedge clk);
        force_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.tx_start, bus.ack, bus.active} !== '0) begin
                n_fail++; $display("FAIL withdraw_%0d: got start=%b ack=%b active=%b, want 0",
                                   i, bus.tx_start, bus.ack, bus.active);
            end
        end
    endtask

    task automatic test_reset_mid();
        int exp;
        bit ok;
        bit reached;
        req_v = 4'b1000;
        drive();
        wait_start(10, ok);
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            @(negedge clk);
            if (bus.dbg_state == WAIT_DONE) reached = 1'b1;
        end
        n_checks++;
        if (!ok || !reached) begin
            n_fail++; $display("FAIL mid_reach: got start=%b wait_done=%b, want 1/1", ok, reached);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.ack, bus.tx_start, bus.tx_data, bus.grant_id, bus.active, bus.err_timeout} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outs: got ack=%b start=%b data=%h gid=%0d active=%b err=%b, want 0",
                               bus.ack, bus.tx_start, bus.tx_data, bus.grant_id, bus.active, bus.err_timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        exp   = model_pick(req_v, m_ptr);
        @(negedge clk);
        n_checks++;
        if (bus.tx_start !== 1'b1 || bus.ack !== 4'b1000 || bus.grant_id !== IDW'(exp)) begin
            n_fail++; $display("FAIL mid_regrant: got start=%b ack=%b gid=%0d, want 1/1000/%0d",
                               bus.tx_start, bus.ack, bus.grant_id, exp);
        end
        m_ptr = (exp + 1) % N;
        req_v = '0;
        drive();
        wait_idle(40, ok);
    endtask

    task automatic test_random();
        logic [N-1:0] prev_req;
        logic [W-1:0] prev_data [N];
        logic [W-1:0] exp_q [$];
        logic [W-1:0] cur_data;
        int           waits [N];
        int           exp;
        int           raised;
        int           granted;
        prev_req = req_v;
        for (int i = 0; i < N; i++) begin
            prev_data[i] = data_v[i];
            waits[i]     = 0;
        end
        cur_data = '0;
        raised   = 0;
        granted  = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                exp = model_pick(prev_req, m_ptr);
                n_checks++;
                if (exp < 0) begin
                    n_fail++; $display("FAIL rand_spurious: got tx_start with gid=%0d, want none", bus.grant_id);
                end else begin
                    exp_q.push_back(prev_data[exp]);
                    cur_data = exp_q.pop_front();
                    if (bus.grant_id !== IDW'(exp) || bus.ack !== N'(1) << exp || bus.tx_data !== cur_data) begin
                        n_fail++; $display("FAIL rand_grant: got gid=%0d ack=%b data=%h, want %0d/%b/%h",
                                           bus.grant_id, bus.ack, bus.tx_data, exp, N'(1) << exp, cur_data);
                    end
                    n_checks++;
                    if (waits[exp] > N - 1) begin
                        n_fail++; $display("FAIL rand_fair: got %0d grants waited by %0d, want <= %0d", waits[exp], exp, N - 1);
                    end
                    for (int i = 0; i < N; i++) if (i != exp && prev_req[i]) waits[i]++;
                    waits[exp] = 0;
                    m_ptr      = (exp + 1) % N;
                    req_v[exp] = 1'b0;
                    granted++;
                end
            end else begin
                n_checks++;
                if (bus.ack !== '0) begin
                    n_fail++; $display("FAIL rand_ack_idle: got ack=%b without tx_start, want 0", bus.ack);
                end
                if (bus.active === 1'b1) begin
                    n_checks++;
                    if (bus.tx_data !== cur_data) begin
                        n_fail++; $display("FAIL rand_data_hold: got %h, want %h", bus.tx_data, cur_data);
                    end
                end
            end
            if (c < 500) begin
                for (int i = 0; i < N; i++) begin
                    if (!req_v[i] && $urandom_range(0, 3) == 0) begin
                        req_v[i] = 1'b1;
                        raised++;
                    end
                end
            end
            for (int i = 0; i < N; i++) if (!req_v[i] || !prev_req[i]) data_v[i] = W'($urandom);
            drive();
            prev_req = req_v;
            for (int i = 0; i < N; i++) prev_data[i] = data_v[i];
            if (c >= 500 && req_v == '0 && bus.active === 1'b0) break;
        end
        n_checks++;
        if (granted !== raised || req_v !== '0) begin
            n_fail++; $display("FAIL rand_drain: got %0d grants for %0d requests (pending %b), want equal", granted, raised, req_v);
        end
    endtask

    initial begin
        req_v = '0;
        for (int i = 0; i < N; i++) data_v[i] = '0;
        m_ptr = 0;
        drive();
        test_reset();
        test_single();
        test_contention();
        test_rotation();
        test_timeout();
        test_busy_engine();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit engine among NUM_REQ requesters, each presenting a byte plus a request.
- Selects requesters round-robin and issues a one-cycle start pulse with the granted byte to the engine.
- Tracks the engine's busy signal through the whole frame and flags an error if the engine never acknowledges.
- Sits between the requesting logic (command/status sources) and the tx engine; its tx_start/tx_data drive the engine's start/data inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width per requester.
- BUSY_TIMEOUT, 15, max cycles from tx_start until tx_busy must rise (1..255).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request; held until matching ack bit.
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester i at bits [i*DATA_W +: DATA_W].
- ack  output  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- tx_start  output  1  one-cycle start pulse to the tx engine.
- tx_data  output  DATA_W  byte to the tx engine; stable from tx_start until return to IDLE.
- tx_busy  input  1  engine busy/ocupado.
- grant_id  output  $clog2(NUM_REQ)  index of current/last granted requester.
- active  output  1  high whenever the state is not IDLE.
- err_timeout  output  1  sticky error: busy never rose; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE; ack=0; tx_start=0; tx_data=0; grant_id=0; active=0; err_timeout=0.
  - Round-robin pointer=0, so requester 0 has highest priority first; timeout counter=0.
- Reset asserted mid-frame aborts immediately. Outputs go to reset values; the engine is not informed (it shares rst_n).
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If tx_busy=0 and req!=0, pick winner g: the first set bit searching from pointer upward, with wrap-around.
  - Register tx_data=req_data[g], grant_id=g, and go to ISSUE.
  - If tx_busy=1 (engine busy from elsewhere or residual), stay in IDLE.
- ISSUE (exactly 1 cycle):
  - tx_start=1 and ack[g]=1, both asserted during this cycle only.
  - pointer<=(g+1) mod NUM_REQ; counter<=0; go to WAIT_BUSY.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE.
  - Else counter increments. When counter reaches BUSY_TIMEOUT, set err_timeout=1 and go to IDLE. The byte is dropped and not retried.
- WAIT_DONE:
  - When tx_busy=0, go to IDLE. The next grant may be decided in that same IDLE cycle.
  - No timeout in this state.
- Latency: a request arriving in IDLE with the engine free gives ack/tx_start on the next cycle, so 1 cycle of decision latency.
- Minimum gap between consecutive tx_start pulses is one engine frame + 2 cycles.
- Requester withdrawing req before ack: not granted, no ack, no side effects.
- Data is sampled at the decision edge only; later req_data changes are ignored.
- Simultaneous requests are served in rotating order. No requester waits more than NUM_REQ-1 grants while holding req.
- Single requester continuously requesting: granted every frame; the pointer still advances.
- ack is never asserted for more than one requester at once; tx_start and ack are always coincident.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE) as a 2-bit typedef.
  - Default constants NUM_REQ_DEF=4 and BUSY_TIMEOUT_DEF=15.
- One sub-module, uart_rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: winner index, valid.
  - Implemented with a double-width mask scheme; instantiated once in the arbiter.
- FSM, counter and registers stay in uart_tx_arbiter.

Test Plan:
- Tx model for all tests: busy rises 1 cycle after tx_start and stays high 10 cycles.
- Single request: req=4'b0100, req_data[2]=8'hA5 -> one cycle later tx_start=1, ack=4'b0100, tx_data=8'hA5, grant_id=2; active falls 1 cycle after busy falls.
- Contention: from reset, req=4'b1111 held and each bit dropped on its ack -> grant order 0,1,2,3; four tx_start pulses, each separated by 12 cycles.
- Rotation fairness: pointer=2 after granting 1, then req=4'b0011 with both held -> grant 0, then 1. Requester 1 never wins twice before 0 is served.
- Timeout: tx model ignores start (busy stays 0), req=4'b0001 -> ack pulse, then err_timeout=1 exactly 15 cycles after tx_start, state IDLE; err_timeout stays 1 until rst_n=0.
- Busy engine at request: tx_busy forced 1 with req=4'b0010 -> no ack and no tx_start; release busy -> ack/tx_start 1 cycle after tx_busy falls.
- Reset mid-frame: assert rst_n=0 in WAIT_DONE -> all outputs 0 in the same cycle; after release, the pending req=4'b1000 is granted with grant_id=3.
